ama_riscv_imm_ctrl: RTL and testbench

//  Decode-stage controller that sequences the immediate generator.
//  - Accepts instructions from fetch over a valid/ready handshake and registers them (ID pipeline register).
//  - Decodes the opcode into the generator's select and enable.
//  - Presents inst[31:7] to the generator.
//  - Handles stall, flush and a post-reset NOP injection window, so the generator never sees stale or garbage input.

---
 rtl/ama_riscv_imm_ctrl.sv | 131 +++++++++++++
 tb/tb_ama_riscv_imm_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_imm_ctrl.sv
// Decode-stage controller for the immediate generator: ID pipeline register,
// opcode decode to generator select/enable, stall/flush handling and post-reset NOP window.
module ama_riscv_imm_ctrl #(
  parameter int          RST_NOP_CYCLES = 3,
  parameter logic [31:0] NOP_INST       = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_in,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        ig_en,
  output logic [3:0]  ig_sel,
  output logic [24:0] ig_in,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic        illegal_inst,
  output logic [1:0]  state
);

  localparam logic [3:0] IG_DISABLED = 4'd0;
  localparam logic [3:0] IG_I_TYPE   = 4'd1;
  localparam logic [3:0] IG_S_TYPE   = 4'd2;
  localparam logic [3:0] IG_B_TYPE   = 4'd3;
  localparam logic [3:0] IG_J_TYPE   = 4'd4;
  localparam logic [3:0] IG_U_TYPE   = 4'd5;

  // Counter only needs to reach RST_NOP_CYCLES-1.
  localparam int              CW       = (RST_NOP_CYCLES > 1) ? $clog2(RST_NOP_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(RST_NOP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST_NOP = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    dec_sel;
  logic          dec_illegal;
  logic          load;

  // Handshake: an instruction transfers on a rising edge where inst_valid && inst_ready;
  // inst_ready is only high in RUN without stall, and inst_in must be held until it transfers.
  assign inst_ready = (state_q == ST_RUN) && !stall;
  assign load       = inst_valid && inst_ready;

  always_comb begin
    dec_sel     = IG_DISABLED;
    dec_illegal = 1'b0;
    case (inst_in[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: dec_sel = IG_I_TYPE;
      7'b0100011:                                     dec_sel = IG_S_TYPE;
      7'b1100011:                                     dec_sel = IG_B_TYPE;
      7'b1101111:                                     dec_sel = IG_J_TYPE;
      7'b0110111, 7'b0010111:                         dec_sel = IG_U_TYPE;
      7'b0110011:                                     dec_sel = IG_DISABLED;
      default:                                        dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST_NOP;
      cnt_q        <= '0;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      ig_sel       <= IG_DISABLED;
      illegal_inst <= 1'b0;
    end else begin
      case (state_q)
        ST_RST_NOP: begin
          // Flush is irrelevant here: the register already carries bubbles.
          id_inst      <= NOP_INST;
          id_valid     <= 1'b0;
          ig_sel       <= IG_DISABLED;
          illegal_inst <= 1'b0;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (flush) begin
            id_inst      <= NOP_INST;
            id_valid     <= 1'b0;
            ig_sel       <= IG_DISABLED;
            illegal_inst <= 1'b0;
          end else if (stall) begin
            illegal_inst <= 1'b0;
            state_q      <= ST_HOLD;
          end else if (load) begin
            id_inst      <= inst_in;
            id_valid     <= 1'b1;
            ig_sel       <= dec_sel;
            illegal_inst <= dec_illegal;
          end else begin
            id_inst      <= NOP_INST;
            id_valid     <= 1'b0;
            ig_sel       <= IG_DISABLED;
            illegal_inst <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (flush) begin
            id_inst      <= NOP_INST;
            id_valid     <= 1'b0;
            ig_sel       <= IG_DISABLED;
            illegal_inst <= 1'b0;
            state_q      <= ST_RUN;
          end else begin
            // Held instruction stays in place through the release cycle.
            illegal_inst <= 1'b0;
            if (!stall) state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RST_NOP;
      endcase
    end
  end

  assign ig_en = id_valid && (ig_sel != IG_DISABLED);
  assign ig_in = id_inst[31:7];
  assign state = state_q;

endmodule

// File: tb/tb_ama_riscv_imm_ctrl.sv
// Directed bench for ama_riscv_imm_ctrl: decode vector table plus reset-window,
// stall, flush and mid-HOLD reset sequences.
module tb_ama_riscv_imm_ctrl;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] LUI     = 32'h12345037;
  localparam logic [31:0] SW      = 32'hFE512E23;
  localparam logic [1:0]  S_RST   = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_HOLD  = 2'd2;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_in;
  logic        inst_valid;
  logic        inst_ready;
  logic        stall;
  logic        flush;
  logic        ig_en;
  logic [3:0]  ig_sel;
  logic [24:0] ig_in;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        illegal_inst;
  logic [1:0]  state;

  int checks;
  int errors;

  ama_riscv_imm_ctrl #(.RST_NOP_CYCLES(3), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_in      (inst_in),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .stall        (stall),
    .flush        (flush),
    .ig_en        (ig_en),
    .ig_sel       (ig_sel),
    .ig_in        (ig_in),
    .id_valid     (id_valid),
    .id_inst      (id_inst),
    .illegal_inst (illegal_inst),
    .state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [3:0]  e_sel;
    logic        e_en;
    logic        e_ill;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [31:0] inst, logic valid, logic stl, logic fl,
                              logic [31:0] e_inst, logic e_valid, logic [3:0] e_sel,
                              logic e_en, logic e_ill);
    vec_t v;
    v.inst = inst; v.valid = valid; v.stall = stl; v.flush = fl;
    v.e_inst = e_inst; v.e_valid = e_valid; v.e_sel = e_sel; v.e_en = e_en; v.e_ill = e_ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] inst, input logic valid, input logic stl, input logic fl);
    inst_in    = inst;
    inst_valid = valid;
    stall      = stl;
    flush      = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_id_inst"},  id_inst,             NOP);
    chk({tag, "_id_valid"}, {31'd0, id_valid},     32'd0);
    chk({tag, "_ig_sel"},   {28'd0, ig_sel},       32'd0);
    chk({tag, "_ig_en"},    {31'd0, ig_en},        32'd0);
    chk({tag, "_ig_in"},    {7'd0, ig_in},         {7'd0, NOP[31:7]});
    chk({tag, "_illegal"},  {31'd0, illegal_inst}, 32'd0);
    chk({tag, "_ready"},    {31'd0, inst_ready},   32'd0);
    chk({tag, "_state"},    {30'd0, state},        {30'd0, S_RST});
  endtask

  // Called right after reset release (away from a clock edge); inputs stay as driven.
  task automatic nop_window(input string tag);
    int n;
    n = 0;
    while (!inst_ready && n < 10) begin
      chk({tag, "_win_valid"}, {31'd0, id_valid}, 32'd0);
      chk({tag, "_win_en"},    {31'd0, ig_en},    32'd0);
      n++;
      step();
    end
    chk({tag, "_win_len"}, n, 32'd3);
    chk({tag, "_win_state"}, {30'd0, state}, {30'd0, S_RUN});
  endtask

  initial begin
    logic [31:0] e;
    checks = 0;
    errors = 0;

    vecs[0]  = mk(LUI,          1, 0, 0, LUI,          1, 4'd5, 1, 0);
    vecs[1]  = mk(32'h00A00093, 1, 0, 0, 32'h00A00093, 1, 4'd1, 1, 0);
    vecs[2]  = mk(32'h00002003, 1, 0, 0, 32'h00002003, 1, 4'd1, 1, 0);
    vecs[3]  = mk(32'h000080E7, 1, 0, 0, 32'h000080E7, 1, 4'd1, 1, 0);
    vecs[4]  = mk(32'h00000073, 1, 0, 0, 32'h00000073, 1, 4'd1, 1, 0);
    vecs[5]  = mk(SW,           1, 0, 0, SW,           1, 4'd2, 1, 0);
    vecs[6]  = mk(32'h00208463, 1, 0, 0, 32'h00208463, 1, 4'd3, 1, 0);
    vecs[7]  = mk(32'h008000EF, 1, 0, 0, 32'h008000EF, 1, 4'd4, 1, 0);
    vecs[8]  = mk(32'h00001517, 1, 0, 0, 32'h00001517, 1, 4'd5, 1, 0);
    vecs[9]  = mk(32'h00B50533, 1, 0, 0, 32'h00B50533, 1, 4'd0, 0, 0);
    vecs[10] = mk(32'h0000007F, 1, 0, 0, 32'h0000007F, 1, 4'd0, 0, 1);
    vecs[11] = mk(32'h00000033, 1, 0, 0, 32'h00000033, 1, 4'd0, 0, 0);
    vecs[12] = mk(32'h0000000B, 1, 0, 0, 32'h0000000B, 1, 4'd0, 0, 1);
    vecs[13] = mk(32'hDEADBEEF, 0, 0, 0, NOP,          0, 4'd0, 0, 0);
    vecs[14] = mk(LUI,          1, 0, 1, NOP,          0, 4'd0, 0, 0);
    vecs[15] = mk(NOP,          1, 0, 0, NOP,          1, 4'd1, 1, 0);

    // Reset with inst_valid held high
    rst_n = 1'b0;
    drive(LUI, 1, 0, 0);
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    nop_window("rst");
    step();
    chk("lui_sel",   {28'd0, ig_sel},   32'd5);
    chk("lui_en",    {31'd0, ig_en},    32'd1);
    chk("lui_ig_in", {7'd0, ig_in},     32'h002468A0);
    chk("lui_valid", {31'd0, id_valid}, 32'd1);

    // Decode table
    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].valid, vecs[i].stall, vecs[i].flush);
      step();
      e = vecs[i].e_inst;
      chk($sformatf("v%0d_id_inst", i), id_inst, e);
      chk($sformatf("v%0d_ig_in", i),   {7'd0, ig_in}, {7'd0, e[31:7]});
      chk($sformatf("v%0d_valid", i),   {31'd0, id_valid},     {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_sel", i),     {28'd0, ig_sel},       {28'd0, vecs[i].e_sel});
      chk($sformatf("v%0d_en", i),      {31'd0, ig_en},        {31'd0, vecs[i].e_en});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal_inst}, {31'd0, vecs[i].e_ill});
    end

    // Stall for 4 cycles with a new instruction offered
    drive(SW, 1, 0, 0);
    step();
    chk("sw_sel", {28'd0, ig_sel}, 32'd2);
    drive(LUI, 1, 1, 0);
    #1;
    chk("stall_ready", {31'd0, inst_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall%0d_inst", k),  id_inst, SW);
      chk($sformatf("stall%0d_sel", k),   {28'd0, ig_sel},     32'd2);
      chk($sformatf("stall%0d_ready", k), {31'd0, inst_ready}, 32'd0);
      chk($sformatf("stall%0d_state", k), {30'd0, state},      {30'd0, S_HOLD});
    end
    drive(LUI, 1, 0, 0);
    step();
    chk("unstall_state", {30'd0, state}, {30'd0, S_RUN});
    chk("unstall_held",  id_inst, SW);
    step();
    chk("after_stall_load", id_inst, LUI);

    // stall and flush together in RUN
    drive(SW, 1, 0, 0);
    step();
    drive(SW, 1, 1, 1);
    step();
    chk("sf_inst",  id_inst, NOP);
    chk("sf_valid", {31'd0, id_valid}, 32'd0);
    chk("sf_en",    {31'd0, ig_en},    32'd0);
    chk("sf_state", {30'd0, state},    {30'd0, S_RUN});

    // flush while in HOLD
    drive(SW, 1, 0, 0);
    step();
    drive(SW, 1, 1, 0);
    step();
    chk("hf_hold", {30'd0, state}, {30'd0, S_HOLD});
    drive(SW, 1, 1, 1);
    step();
    chk("hf_inst",  id_inst, NOP);
    chk("hf_state", {30'd0, state}, {30'd0, S_RUN});

    // Reset pulsed mid-cycle while in HOLD; flush held during the new NOP window
    drive(SW, 1, 0, 0);
    step();
    drive(LUI, 1, 1, 0);
    step();
    chk("hr_pre_state", {30'd0, state}, {30'd0, S_HOLD});
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("hr");
    drive(LUI, 1, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    nop_window("hr");
    drive(LUI, 1, 0, 0);
    step();
    chk("hr_first_load", id_inst, LUI);
    chk("hr_first_en",   {31'd0, ig_en}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
